// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the display path.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Binary,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     Blank
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;

  logic [BW-1:0]    work_adj;
  logic [BW-1:0]    work_nxt;
  logic [WIDTH-1:0] shift_nxt;
  logic             last;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  // Digit i>0 is blank when it and every higher digit are zero
  function automatic logic [DIGITS-1:0] blank_of(
    input logic [BW-1:0] v
  );
    logic [DIGITS-1:0] b;
    logic              upper_zero;
    b          = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (v[4*i +: 4] == 4'd0);
      b[i]       = upper_zero;
    end
    return b;
  endfunction
`endif

  // Add-3 correction on every working digit that is 5 or more
  always_comb begin
    work_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end else begin
        work_adj[4*i +: 4] = work_q[4*i +: 4];
      end
    end
  end

  // One-bit left shift of the {working BCD, shift register} pair
  always_comb begin
    work_nxt  = {work_adj[BW-2:0], shift_q[WIDTH-1]};
    shift_nxt = shift_q << 1;
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d = blank_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          shift_d = Binary;
          work_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_nxt;
        work_d  = work_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          bcd_d   = work_nxt;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef LEADING_ZERO_BLANK_EN
          blank_d = blank_of(work_nxt);
`endif
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank mask register; reset shows a single "0"
  always_ff @(posedge Clk) begin
    if (Rst) begin
      blank_q <= blank_of('0);
    end else begin
      blank_q <= blank_d;
    end
  end

  assign Blank = blank_q;
`else
  assign Blank = '0;
`endif

  assign Busy = (state_q == SHIFT);
  assign Done = done_q;
  assign BCD  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: 8-bit and 16-bit instances
// checked against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start8;
  logic [7:0]  bin8;
  logic        busy8;
  logic        done8;
  logic [11:0] bcd8;
  logic [2:0]  blank8;
  logic        start16;
  logic [15:0] bin16;
  logic        busy16;
  logic        done16;
  logic [19:0] bcd16;
  logic [4:0]  blank16;

  int tests = 0;
  int fails = 0;
  logic [11:0] prev8;
  logic [2:0]  prevb8;
  logic [19:0] prev16;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
    .Clk(clk), .Rst(rst), .Start(start8),
    .Binary(bin8), .Busy(busy8), .Done(done8),
    .BCD(bcd8), .Blank(blank8)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (
    .Clk(clk), .Rst(rst), .Start(start16),
    .Binary(bin16), .Busy(busy16), .Done(done16),
    .BCD(bcd16), .Blank(blank16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of v by plain division
  function automatic logic [39:0] ref_bcd(
    input longint unsigned v, input int d
  );
    logic [39:0] r;
    longint unsigned p;
    r = '0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i>0 blank when v < 10^i (macro builds only)
  function automatic logic [39:0] ref_blank(
    input longint unsigned v, input int d
  );
    logic [39:0] r;
    longint unsigned p;
    r = '0;
    p = 10;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 1; i < d; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
`else
    p = p + longint'(d) + v;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string tag, input logic [39:0] obs,
    input logic [39:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Convert v on the 8-bit unit with random Start/Binary
  // noise during the shift phase
  task automatic run8(input int unsigned v);
    logic [11:0] e;
    e = 12'(ref_bcd(v, 3));
    start8 = 1'b1;
    bin8   = 8'(v);
    tick();
    for (int j = 0; j < 8; j++) begin
      start8 = 1'($urandom);
      bin8   = 8'($urandom);
      check("busy8", 40'(busy8), 40'(1));
      check("nodone8", 40'(done8), 40'(0));
      check("hold8", 40'(bcd8), 40'(prev8));
      check("holdb8", 40'(blank8), 40'(prevb8));
      tick();
    end
    start8 = 1'b0;
    check("done8", 40'(done8), 40'(1));
    check("idle8", 40'(busy8), 40'(0));
    check("bcd8", 40'(bcd8), 40'(e));
    check("blank8", 40'(blank8), ref_blank(v, 3));
    prev8  = e;
    prevb8 = 3'(ref_blank(v, 3));
    tick();
    check("pulse8", 40'(done8), 40'(0));
  endtask

  task automatic run16(input int unsigned v);
    logic [19:0] e;
    e = 20'(ref_bcd(v, 5));
    start16 = 1'b1;
    bin16   = 16'(v);
    tick();
    start16 = 1'b0;
    bin16   = 16'($urandom);
    for (int j = 0; j < 16; j++) begin
      check("busy16", 40'(busy16), 40'(1));
      check("hold16", 40'(bcd16), 40'(prev16));
      tick();
    end
    check("done16", 40'(done16), 40'(1));
    check("idle16", 40'(busy16), 40'(0));
    check("bcd16", 40'(bcd16), 40'(e));
    check("blank16", 40'(blank16), ref_blank(v, 5));
    prev16 = e;
    tick();
  endtask

  initial begin
    int unsigned r;
    rst     = 1'b1;
    start8  = 1'b0;
    bin8    = '0;
    start16 = 1'b0;
    bin16   = '0;
    prev8   = '0;
    prevb8  = 3'(ref_blank(0, 3));
    prev16  = '0;
    tick();
    tick();
    check("rst_busy", 40'(busy8), 40'(0));
    check("rst_done", 40'(done8), 40'(0));
    check("rst_bcd", 40'(bcd8), 40'(0));
    check("rst_blank", 40'(blank8), ref_blank(0, 3));
    check("rst_blank16", 40'(blank16),
          ref_blank(0, 5));
    rst = 1'b0;
    tick();

    run8(255);
    run8(0);
    run8(42);

    // Back-to-back: Start held through Done
    start8 = 1'b1;
    bin8   = 8'd7;
    tick();
    bin8 = 8'd100;
    for (int j = 0; j < 8; j++) tick();
    check("b2b_done1", 40'(done8), 40'(1));
    check("b2b_bcd1", 40'(bcd8), 40'(ref_bcd(7, 3)));
    check("b2b_blk1", 40'(blank8), ref_blank(7, 3));
    tick();
    start8 = 1'b0;
    check("b2b_busy2", 40'(busy8), 40'(1));
    for (int j = 0; j < 7; j++) tick();
    check("b2b_early", 40'(done8), 40'(0));
    tick();
    check("b2b_done2", 40'(done8), 40'(1));
    check("b2b_bcd2", 40'(bcd8), 40'(ref_bcd(100, 3)));
    check("b2b_blk2", 40'(blank8), ref_blank(100, 3));
    prev8  = 12'(ref_bcd(100, 3));
    prevb8 = 3'(ref_blank(100, 3));
    tick();

    // Reset abort in the 4th shift cycle of 200
    start8 = 1'b1;
    bin8   = 8'd200;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 40'(busy8), 40'(0));
    check("abort_done", 40'(done8), 40'(0));
    check("abort_bcd", 40'(bcd8), 40'(0));
    check("abort_blank", 40'(blank8), ref_blank(0, 3));
    prev8  = '0;
    prevb8 = 3'(ref_blank(0, 3));
    prev16 = '0;
    for (int j = 0; j < 10; j++) begin
      check("abort_nodone", 40'(done8), 40'(0));
      tick();
    end
    run8(200);

    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 255);
      run8(r);
    end

    run16(65535);
    run16(1000);
    run16(0);
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 65535);
      run16(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
